// File: rtl/task_3.sv
// Registered WIDTH-bit ripple-carry adder with carry-in and carry-out, signed-overflow and zero flags.
// Free-running with no enable or handshake: inputs are sampled every cycle and results appear one cycle later.

module task_3_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module task_3 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    task_3_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Signed overflow: carry into the MSB differs from the carry out of it.
  always_comb begin
    sum_d  = s;
    cout_d = c[WIDTH];
    ovf_d  = c[WIDTH] ^ c[WIDTH-1];
    zero_d = (s == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_task_3.sv
// Bench for task_3: arithmetic reference model with an expected-result queue, a per-cycle
// compare process, and directed vectors with hand-computed literal results.

module tb_task_3;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  logic [W+2:0] got;
  logic [W+2:0] exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task_3 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .B     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  assign got = {ovf, zero, cout, sum};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Result packed as {ovf, zero, cout, sum}.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    int unsigned total;
    int          signed_total;
    logic [W-1:0] s;
    logic         co, ov, z;
    total        = 32'(ma) + 32'(mb) + 32'(mc);
    s            = total[W-1:0];
    co           = (total >= (32'd1 << W));
    signed_total = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    ov           = (signed_total > ((1 << (W-1)) - 1)) || (signed_total < -(1 << (W-1)));
    z            = (s == '0);
    return {ov, z, co, s};
  endfunction

  task automatic check(input string name, input logic [W+2:0] actual, input logic [W+2:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s @%0t: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
               name, $time, actual[W-1:0], actual[W], actual[W+2], actual[W+1],
               expected[W-1:0], expected[W], expected[W+2], expected[W+1]);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (rst_n) exp_q.push_back(model(a, b, cin));
  end

  always @(negedge rst_n) exp_q.delete();

  always @(negedge clk) begin
    logic [W+2:0] e;
    e = '0;
    if (rst_n && exp_q.size() > 0) e = exp_q.pop_front();
    check("cycle", got, e);
  end

  // ---------------- driver ----------------
  task automatic apply(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic [W+2:0] lit, input string name);
    @(negedge clk);
    a   = ta;
    b   = tb;
    cin = tc;
    check({name, "_model"}, model(ta, tb, tc), lit);
    @(posedge clk);
    #1;
    check(name, got, lit);
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 8'h55;
    b     = 8'h11;
    for (int i = 0; i < 3; i++) begin
      cin = 1'(i);
      @(posedge clk);
      #1;
      check("reset_hold", got, '0);
    end
    a = 'x;
    b = 'x;
    @(posedge clk);
    #1;
    check("reset_x_inputs", got, '0);
    a   = '0;
    b   = '0;
    cin = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;

    apply(8'h09, 8'h06, 1'b0, {1'b0, 1'b0, 1'b0, 8'h0F}, "add_small");
    apply(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 1'b1, 8'h00}, "wrap_zero");
    apply(8'h7F, 8'h00, 1'b1, {1'b1, 1'b0, 1'b0, 8'h80}, "pos_ovf");
    apply(8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 1'b1, 8'h00}, "neg_ovf");
    apply(8'hFF, 8'hFF, 1'b1, {1'b0, 1'b0, 1'b1, 8'hFF}, "max_case");
    apply(8'h00, 8'h00, 1'b1, {1'b0, 1'b0, 1'b0, 8'h01}, "cin_only");
    apply(8'h80, 8'h10, 1'b0, {1'b0, 1'b0, 1'b0, 8'h90}, "pre_reset");

    // Async reset between edges: outputs must clear with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", got, '0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b1;
    #1;
    check("released_no_edge", got, '0);
    @(posedge clk);
    #1;
    check("post_release", got, {1'b0, 1'b0, 1'b0, 8'h47});

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
